uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, input clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, reset baud rate.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, transmit FIFO entries; power of two, 2..256.
REQ-004 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port enable  input  1  peripheral select from address decoder.
REQ-007 SHALL have port mem_valid  input  1  bus request valid.
REQ-008 SHALL have port mem_instr  input  1  instruction fetch flag; ignored.
REQ-009 SHALL have port mem_wstrb  input  4  byte write strobes; 0 = read.
REQ-010 SHALL have port mem_wdata  input  32  write data.
REQ-011 SHALL have port mem_addr  input  32  byte address; only [3:2] decoded.
REQ-012 SHALL have port mem_ready  output  1  transfer complete; tri-state.
REQ-013 SHALL have port mem_rdata  output  32  read data; tri-state.
REQ-014 SHALL have port tx  output  1  serial data, idle high.
REQ-015 SHALL have port irq  output  1  high while FIFO empty and shifter idle.

Function
REQ-016 SHALL drive mem_ready and mem_rdata to high-Z whenever enable is low, so they share bus wires with other peripherals.
REQ-017 SHALL pulse mem_ready for exactly one cycle, the cycle after mem_valid&&enable is sampled with mem_ready low; back-to-back requests complete every second cycle.
REQ-018 SHALL present read data on mem_rdata in the cycle mem_ready is high, else 0 while enabled.
REQ-019 SHALL map addr[3:2]: 0 DATA, 1 STATUS, 2 DIV, 3 reserved (reads 0, writes ignored).
REQ-020 SHALL, on DATA write with wstrb[0]=1, push wdata[7:0] into FIFO in the mem_ready cycle; DATA reads return 0.
REQ-021 SHALL, when FIFO full at push and no pop in the same cycle, drop the byte and set sticky OVF; simultaneous push and pop on full FIFO SHALL accept the push.
REQ-022 SHALL read STATUS as: bit0 full, bit1 empty, bit2 busy (state != IDLE), bit3 OVF, bits[15:8] FIFO count, others 0.
REQ-023 SHALL clear OVF on STATUS write with wstrb[0]=1 and wdata[3]=1; a same-cycle overflow SHALL win (OVF stays 1).
REQ-024 SHALL hold a 16-bit DIV register, reset value CLK_HZ/BAUD-1 (integer division, truncated to 16 bits); writes use wstrb[1:0]; each bit lasts DIV+1 clocks.
REQ-025 SHALL apply a new DIV value at the next bit boundary, never mid-bit.
REQ-026 SHALL implement FSM IDLE->START->DATA->STOP; IDLE->START when FIFO non-empty, popping the head byte that same cycle.
REQ-027 SHALL drive tx low from the first START cycle, then data bits LSB first, then stop bit high, each DIV+1 clocks.
REQ-028 SHALL go STOP->START directly (no idle gap) when FIFO non-empty at end of stop bit, else STOP->IDLE.
REQ-029 SHALL use wrap-around read/write pointers with a separate count (0..FIFO_DEPTH); full = count==FIFO_DEPTH, empty = count==0.

Reset
REQ-030 SHALL, on reset, set tx=1, FSM IDLE, FIFO empty, count 0, OVF 0, DIV to default, mem_ready 0 (when enabled), irq 1.
REQ-031 SHALL, on reset mid-frame, abort the frame: tx high in the cycle after reset is sampled, queued bytes discarded.

Verification (CLK_HZ=1000, BAUD=100 -> DIV=9, bit=10 clocks, FIFO_DEPTH=4)
REQ-032 SHALL verify: write DATA=0x55 -> mem_ready 1 cycle later; tx low 10 clks, then 1,0,1,0,1,0,1,0 (10 clks each), high 10 clks; irq high after 100 clks.
REQ-033 SHALL verify: write 0xA5,0x3C back-to-back -> two frames with no idle gap between stop bit and second start bit.
REQ-034 SHALL verify: 6 writes while shifter busy with first byte -> 5 accepted (1 shifting + 4 queued), 6th dropped, STATUS bit0=1, bit3=1; STATUS write 0x8 clears bit3.
REQ-035 SHALL verify: write DIV=4 during a frame -> current bit keeps 10 clks, subsequent bits 5 clks.
REQ-036 SHALL verify: reset asserted mid-data-bit -> tx=1 next cycle, STATUS reads 0x0000_0002, no further frame.
REQ-037 SHALL verify: enable low with mem_valid high -> mem_ready and mem_rdata high-Z, no FIFO push.

Source files
------------

// File: rtl/uart_tx.sv
// Memory-mapped UART transmitter: byte FIFO, runtime baud divisor, 8N1 framing.
// Bus outputs float when the peripheral is not selected so they can share wires.
module uart_tx #(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_wdata,
  input  logic [31:0] mem_addr,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        tx,
  output logic        irq
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
  localparam logic [15:0]   DIV_RESET  = 16'(CLK_HZ / BAUD - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_next;
  logic          ready_r;
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [7:0]    count8;
  logic          ovf;
  logic [15:0]   div_reg, div_act, baud_cnt;
  logic [7:0]    shreg;
  logic [2:0]    bit_idx;
  logic          xfer, push_req, push, pop, full, empty, bit_end, busy, ovf_set, ovf_clr;
  logic [1:0]    reg_sel;
  logic [31:0]   status, read_val;
  logic          unused_bits;

  assign unused_bits = ^{mem_instr, mem_wstrb[3:2], mem_wdata[31:16], mem_addr[31:4], mem_addr[1:0]};

  // A transfer commits at the clock edge that ends the one-cycle ready pulse.
  assign reg_sel  = mem_addr[3:2];
  assign xfer     = ready_r && enable && mem_valid;
  assign push_req = xfer && (reg_sel == 2'd0) && mem_wstrb[0];
  assign ovf_clr  = xfer && (reg_sel == 2'd1) && mem_wstrb[0] && mem_wdata[3];

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign bit_end = (baud_cnt == div_act);
  assign pop     = !empty && ((state == IDLE) || ((state == STOP) && bit_end));
  assign push    = push_req && (!full || pop);
  assign ovf_set = push_req && full && !pop;

  always_ff @(posedge clk) begin
    if (reset) ready_r <= 1'b0;
    else       ready_r <= enable && mem_valid && !ready_r;
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= mem_wdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Overflow set takes priority over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (reset)        ovf <= 1'b0;
    else if (ovf_set) ovf <= 1'b1;
    else if (ovf_clr) ovf <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_reg <= DIV_RESET;
    end else if (xfer && (reg_sel == 2'd2)) begin
      if (mem_wstrb[0]) div_reg[7:0]  <= mem_wdata[7:0];
      if (mem_wstrb[1]) div_reg[15:8] <= mem_wdata[15:8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!empty) state_next = START;
      START:   if (bit_end) state_next = DATA;
      DATA:    if (bit_end && (bit_idx == 3'd7)) state_next = STOP;
      STOP:    if (bit_end) state_next = empty ? IDLE : START;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    tx   = 1'b1;
    busy = 1'b1;
    case (state)
      IDLE:    busy = 1'b0;
      START:   tx = 1'b0;
      DATA:    tx = shreg[0];
      default: ;
    endcase
  end

  // div_act is reloaded only at bit boundaries so a divisor write never stretches a bit in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      baud_cnt <= '0;
      div_act  <= DIV_RESET;
      shreg    <= '0;
      bit_idx  <= '0;
    end else if (pop) begin
      shreg    <= fifo_mem[rd_ptr];
      baud_cnt <= '0;
      div_act  <= div_reg;
      bit_idx  <= '0;
    end else if (state != IDLE) begin
      if (bit_end) begin
        baud_cnt <= '0;
        div_act  <= div_reg;
        if (state == DATA) begin
          shreg   <= {1'b0, shreg[7:1]};
          bit_idx <= bit_idx + 1'b1;
        end
      end else begin
        baud_cnt <= baud_cnt + 1'b1;
      end
    end
  end

  assign irq    = !busy && empty;
  assign count8 = 8'(count);
  assign status = {16'h0000, count8, 4'h0, ovf, busy, empty, full};

  always_comb begin
    read_val = '0;
    if (ready_r) begin
      case (reg_sel)
        2'd1:    read_val = status;
        2'd2:    read_val = {16'h0000, div_reg};
        default: read_val = '0;
      endcase
    end
  end

  assign mem_ready = enable ? ready_r  : 1'bz;
  assign mem_rdata = enable ? read_val : 32'bz;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: bus protocol, FIFO/overflow, framing, divisor change, reset.
// tx/irq are logged every cycle; expected serial streams are built from byte lists and bit lengths.
module tb_uart_tx;
  localparam int CLK_HZ  = 1000;
  localparam int BAUD    = 100;
  localparam int DEPTH   = 4;
  localparam int BIT_LEN = CLK_HZ / BAUD;
  localparam int LOGN    = 16384;

  logic        clk = 1'b0;
  logic        reset, enable, mem_valid, mem_instr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata, mem_addr;
  // Pulled-up bus wires: an undriven (high-Z) bus reads back as all ones.
  tri1         mem_ready_w;
  tri1 [31:0]  mem_rdata_w;
  logic        tx, irq;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  logic tx_log  [LOGN];
  logic irq_log [LOGN];
  logic exp_q [$];

  uart_tx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .enable(enable), .mem_valid(mem_valid), .mem_instr(mem_instr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_addr(mem_addr),
    .mem_ready(mem_ready_w), .mem_rdata(mem_rdata_w), .tx(tx), .irq(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (cyc < LOGN) begin tx_log[cyc] = tx; irq_log[cyc] = irq; end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One bus transaction; returns ready latency (-1 if none) and data seen with ready.
  task automatic bus(input logic [1:0] sel, input logic [31:0] data, input logic [3:0] strb,
                     output int lat, output logic [31:0] rd);
    logic [31:0] r;
    r = $urandom();
    enable = 1'b1; mem_valid = 1'b1; mem_instr = r[0];
    mem_addr = {r[31:4], sel, r[1:0]};
    mem_wdata = data; mem_wstrb = strb;
    lat = -1; rd = '0;
    for (int i = 1; i <= 8 && lat < 0; i++) begin
      @(posedge clk); #1;
      if (mem_ready_w === 1'b1) begin lat = i; rd = mem_rdata_w; end
    end
    @(posedge clk); #1;
    mem_valid = 1'b0; mem_wstrb = '0;
  endtask

  task automatic add_frame(input logic [7:0] b, input int first_len, input int len);
    for (int k = 0; k < 10; k++) begin
      logic lvl;
      lvl = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
      repeat ((k == 0) ? first_len : len) exp_q.push_back(lvl);
    end
  endtask

  function automatic int stream_errs(input int t0, output int bad_off);
    int e;
    logic want;
    e = 0; bad_off = -1;
    for (int i = 0; i <= exp_q.size() + 5; i++) begin
      want = (i >= 1 && i <= exp_q.size()) ? exp_q[i-1] : 1'b1;
      if (tx_log[t0+i] !== want) begin
        if (e == 0) bad_off = i;
        e++;
      end
    end
    return e;
  endfunction

  task automatic wait_until(input int target);
    while (cyc < target) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    int lat; logic [31:0] rd;
    reset = 1'b1; enable = 1'b1; mem_valid = 1'b0; mem_instr = 1'b0;
    mem_wstrb = '0; mem_wdata = '0; mem_addr = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    checks++; if (tx !== 1'b1) begin failures++; $display("FAIL reset_tx: got %b want 1", tx); end
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL reset_irq: got %b want 1", irq); end
    checks++; if (mem_ready_w !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b want 0", mem_ready_w); end
    checks++; if (mem_rdata_w !== 32'h0) begin failures++; $display("FAIL reset_rdata: got %h want 0", mem_rdata_w); end
    bus(2'd1, 32'h0, 4'h0, lat, rd);
    checks++; if (lat !== 1) begin failures++; $display("FAIL reset_status_lat: got %0d want 1", lat); end
    checks++; if (rd !== 32'h2) begin failures++; $display("FAIL reset_status: got %h want 00000002", rd); end
    bus(2'd2, 32'h0, 4'h0, lat, rd);
    checks++; if (rd !== 32'd9) begin failures++; $display("FAIL reset_div: got %h want 00000009", rd); end
  endtask

  task automatic test_regs();
    int lat; logic [31:0] rd; logic [3:0] pat;
    bus(2'd0, $urandom(), 4'h0, lat, rd);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL data_read: got %h want 0", rd); end
    bus(2'd3, $urandom(), 4'hF, lat, rd);
    bus(2'd3, 32'h0, 4'h0, lat, rd);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL reserved_read: got %h want 0", rd); end
    bus(2'd2, 32'h0000_ABCD, 4'b0010, lat, rd);
    bus(2'd2, 32'h0, 4'h0, lat, rd);
    checks++; if (rd !== 32'h0000_AB09) begin failures++; $display("FAIL div_strobe: got %h want 0000ab09", rd); end
    bus(2'd2, 32'd9, 4'b0011, lat, rd);
    bus(2'd2, 32'h0, 4'h0, lat, rd);
    checks++; if (rd !== 32'd9) begin failures++; $display("FAIL div_restore: got %h want 00000009", rd); end
    // Request held valid: ready must come on alternate cycles.
    enable = 1'b1; mem_valid = 1'b1; mem_wstrb = '0; mem_addr = 32'h8;
    pat = '0;
    for (int i = 0; i < 4; i++) begin @(posedge clk); #1; pat[i] = mem_ready_w; end
    mem_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (pat !== 4'b0101) begin failures++; $display("FAIL ready_pattern: got %b want 0101", pat); end
    bus(2'd1, 32'h0, 4'h0, lat, rd);
    checks++; if (rd !== 32'h2) begin failures++; $display("FAIL regs_no_push: got %h want 00000002", rd); end
  endtask

  task automatic test_single_frame();
    int lat, t0, errs, bad; logic [31:0] rd, r; logic [7:0] b;
    for (int n = 0; n < 2; n++) begin
      r = $urandom();
      b = (n == 0) ? 8'h55 : r[7:0];
      bus(2'd0, {r[31:8], b}, {r[3:1], 1'b1}, lat, rd);
      t0 = cyc;
      checks++; if (lat !== 1) begin failures++; $display("FAIL frame_lat: got %0d want 1", lat); end
      checks++; if (mem_ready_w !== 1'b0) begin failures++; $display("FAIL frame_ready_pulse: got %b want 0", mem_ready_w); end
      exp_q.delete();
      add_frame(b, BIT_LEN, BIT_LEN);
      wait_until(t0 + exp_q.size() + 8);
      errs = stream_errs(t0, bad);
      checks++; if (errs !== 0) begin failures++; $display("FAIL frame_%h: got %0d bad cycles first at offset %0d want 0", b, errs, bad); end
      checks++; if (irq_log[t0+exp_q.size()] !== 1'b0 || irq_log[t0+exp_q.size()+1] !== 1'b1) begin
        failures++; $display("FAIL frame_irq: got %b%b want 01", irq_log[t0+exp_q.size()], irq_log[t0+exp_q.size()+1]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat, t0, errs, bad; logic [31:0] rd, r; logic [7:0] bytes [5];
    bytes[0] = 8'hA5; bytes[1] = 8'h3C;
    for (int i = 2; i < 5; i++) begin r = $urandom(); bytes[i] = r[7:0]; end
    exp_q.delete();
    t0 = 0;
    for (int i = 0; i < 5; i++) begin
      r = $urandom();
      bus(2'd0, {r[31:8], bytes[i]}, 4'b0001, lat, rd);
      if (i == 0) t0 = cyc;
      checks++; if (lat !== 1) begin failures++; $display("FAIL b2b_lat%0d: got %0d want 1", i, lat); end
      add_frame(bytes[i], BIT_LEN, BIT_LEN);
    end
    wait_until(t0 + exp_q.size() + 8);
    errs = stream_errs(t0, bad);
    checks++; if (errs !== 0) begin failures++; $display("FAIL b2b_stream: got %0d bad cycles first at offset %0d want 0", errs, bad); end
    checks++; if (irq_log[t0+exp_q.size()+1] !== 1'b1) begin failures++; $display("FAIL b2b_irq: got %b want 1", irq_log[t0+exp_q.size()+1]); end
  endtask

  task automatic test_overflow();
    int lat, t0, errs, bad; logic [31:0] rd, r; logic [7:0] bytes [7];
    for (int i = 0; i < 7; i++) begin r = $urandom(); bytes[i] = r[7:0]; end
    exp_q.delete();
    t0 = 0;
    for (int i = 0; i < 6; i++) begin
      bus(2'd0, {24'h0, bytes[i]}, 4'b0001, lat, rd);
      if (i == 0) t0 = cyc;
      if (i < 5) add_frame(bytes[i], BIT_LEN, BIT_LEN);
    end
    bus(2'd1, 32'h0, 4'h0, lat, rd);
    checks++; if (rd !== 32'h0000_040D) begin failures++; $display("FAIL ovf_status: got %h want 0000040d", rd); end
    bus(2'd1, 32'h8, 4'b0001, lat, rd);
    bus(2'd1, 32'h0, 4'h0, lat, rd);
    checks++; if (rd !== 32'h0000_0405) begin failures++; $display("FAIL ovf_clear: got %h want 00000405", rd); end
    // Push timed to commit on the same edge the full FIFO pops for the next frame.
    wait_until(t0 + 99);
    bus(2'd0, {24'h0, bytes[6]}, 4'b0001, lat, rd);
    add_frame(bytes[6], BIT_LEN, BIT_LEN);
    bus(2'd1, 32'h0, 4'h0, lat, rd);
    checks++; if (rd !== 32'h0000_0405) begin failures++; $display("FAIL full_push_pop: got %h want 00000405", rd); end
    wait_until(t0 + exp_q.size() + 8);
    errs = stream_errs(t0, bad);
    checks++; if (errs !== 0) begin failures++; $display("FAIL ovf_stream: got %0d bad cycles first at offset %0d want 0", errs, bad); end
    bus(2'd1, 32'h0, 4'h0, lat, rd);
    checks++; if (rd !== 32'h2) begin failures++; $display("FAIL ovf_final_status: got %h want 00000002", rd); end
  endtask

  task automatic test_div_change();
    int lat, t0, errs, bad; logic [31:0] rd, r; logic [7:0] b;
    r = $urandom(); b = r[7:0];
    bus(2'd0, {24'h0, b}, 4'b0001, lat, rd);
    t0 = cyc;
    bus(2'd2, 32'd4, 4'b0011, lat, rd);
    checks++; if (lat !== 1) begin failures++; $display("FAIL div_write_lat: got %0d want 1", lat); end
    exp_q.delete();
    add_frame(b, BIT_LEN, 5);
    wait_until(t0 + exp_q.size() + 8);
    errs = stream_errs(t0, bad);
    checks++; if (errs !== 0) begin failures++; $display("FAIL div_stream: got %0d bad cycles first at offset %0d want 0", errs, bad); end
    checks++; if (irq_log[t0+exp_q.size()] !== 1'b0 || irq_log[t0+exp_q.size()+1] !== 1'b1) begin
      failures++; $display("FAIL div_irq: got %b%b want 01", irq_log[t0+exp_q.size()], irq_log[t0+exp_q.size()+1]);
    end
    bus(2'd2, 32'h0, 4'h0, lat, rd);
    checks++; if (rd !== 32'd4) begin failures++; $display("FAIL div_readback: got %h want 00000004", rd); end
    bus(2'd2, 32'd9, 4'b0011, lat, rd);
  endtask

  task automatic test_reset_mid_frame();
    int lat, t0, t1, errs; logic [31:0] rd, r;
    r = $urandom();
    bus(2'd0, 32'h0, 4'b0001, lat, rd);
    t0 = cyc;
    bus(2'd0, {24'h0, r[7:0]}, 4'b0001, lat, rd);
    wait_until(t0 + 35);
    checks++; if (tx !== 1'b0) begin failures++; $display("FAIL pre_reset_tx: got %b want 0", tx); end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (tx !== 1'b1) begin failures++; $display("FAIL midreset_tx: got %b want 1", tx); end
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL midreset_irq: got %b want 1", irq); end
    reset = 1'b0;
    bus(2'd1, 32'h0, 4'h0, lat, rd);
    checks++; if (rd !== 32'h0000_0002) begin failures++; $display("FAIL midreset_status: got %h want 00000002", rd); end
    bus(2'd2, 32'h0, 4'h0, lat, rd);
    checks++; if (rd !== 32'd9) begin failures++; $display("FAIL midreset_div: got %h want 00000009", rd); end
    t1 = cyc;
    wait_until(t1 + 252);
    errs = 0;
    for (int i = 0; i <= 250; i++) if (tx_log[t1+i] !== 1'b1) errs++;
    checks++; if (errs !== 0) begin failures++; $display("FAIL midreset_quiet: got %0d low cycles want 0", errs); end
  endtask

  task automatic test_enable_low();
    int lat, bad_rdy, bad_dat; logic [31:0] rd;
    enable = 1'b0; mem_valid = 1'b1; mem_addr = 32'h0; mem_wstrb = 4'b0001; mem_wdata = $urandom();
    bad_rdy = 0; bad_dat = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (mem_ready_w !== 1'b1) bad_rdy++;
      if (mem_rdata_w !== 32'hFFFF_FFFF) bad_dat++;
    end
    checks++; if (bad_rdy !== 0) begin failures++; $display("FAIL disabled_ready_z: got %0d driven cycles want 0", bad_rdy); end
    checks++; if (bad_dat !== 0) begin failures++; $display("FAIL disabled_rdata_z: got %0d driven cycles want 0", bad_dat); end
    mem_valid = 1'b0; mem_wstrb = '0; enable = 1'b1;
    @(posedge clk); #1;
    checks++; if (mem_ready_w !== 1'b0) begin failures++; $display("FAIL reenabled_ready: got %b want 0", mem_ready_w); end
    bus(2'd1, 32'h0, 4'h0, lat, rd);
    checks++; if (rd !== 32'h2) begin failures++; $display("FAIL disabled_no_push: got %h want 00000002", rd); end
  endtask

  initial begin
    test_reset();
    test_regs();
    test_single_frame();
    test_back_to_back();
    test_overflow();
    test_div_change();
    test_reset_mid_frame();
    test_enable_low();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
